// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 on a 25.175 MHz pixel clock) and sync polarity encoding.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef enum logic {
        SYNC_NEG = 1'b0,
        SYNC_POS = 1'b1
    } syncPol_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping up-counter that decodes the visible region and the sync window.
// The segment order along the axis is active, front porch, sync, back porch.
module vga_axis_counter #(
    parameter int TOTAL  = 800,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int W      = $clog2(TOTAL)
) (
    input  logic         clk25175KHz,
    input  logic         reset,
    input  logic         advance,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         syncC
);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

    always_ff @(posedge clk25175KHz) begin
        if (reset) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

    always_comb begin
        wrap   = (count == LAST);
        active = (count < ACT_END);
        syncC  = (count >= SYNC_LO) && (count < SYNC_HI);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Full-frame VGA timing generator: pixel coordinates for the pixel source, plus colour and
// syncs registered together so they reach the DAC/pins on the same clock edge.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = VGA_H_ACTIVE,
    parameter int   H_FP       = VGA_H_FP,
    parameter int   H_SYNC     = VGA_H_SYNC,
    parameter int   H_BP       = VGA_H_BP,
    parameter int   V_ACTIVE   = VGA_V_ACTIVE,
    parameter int   V_FP       = VGA_V_FP,
    parameter int   V_SYNC     = VGA_V_SYNC,
    parameter int   V_BP       = VGA_V_BP,
    parameter logic H_SYNC_POL = SYNC_NEG,
    parameter logic V_SYNC_POL = SYNC_NEG,
    parameter int   COLOR_W    = 1,
    localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  HW         = $clog2(H_TOTAL),
    localparam int  VW         = $clog2(V_TOTAL)
) (
    input  logic               clk25175KHz,
    input  logic               reset,
    input  logic [COLOR_W-1:0] redIn,
    input  logic [COLOR_W-1:0] greenIn,
    input  logic [COLOR_W-1:0] blueIn,
    output logic [HW-1:0]      x,
    output logic [VW-1:0]      y,
    output logic               pixelReq,
    output logic               lineStart,
    output logic               frameStart,
    output logic [COLOR_W-1:0] redOut,
    output logic [COLOR_W-1:0] greenOut,
    output logic [COLOR_W-1:0] blueOut,
    output logic               hSync,
    output logic               vSync,
    output logic               activeOut
);

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || COLOR_W < 1) begin : gBadParam
            $error("vga_timing_gen: every timing parameter and COLOR_W must be at least 1");
        end
    endgenerate

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hWrap;
    logic          hActive;
    logic          vActive;
    logic          hSyncC;
    logic          vSyncC;
    logic          visC;

    vga_axis_counter #(
        .TOTAL  (H_TOTAL),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .W      (HW)
    ) uHoriz (
        .clk25175KHz (clk25175KHz),
        .reset       (reset),
        .advance     (1'b1),
        .count       (hcnt),
        .wrap        (hWrap),
        .active      (hActive),
        .syncC       (hSyncC)
    );

    // Lines advance only when the horizontal counter rolls over.
    vga_axis_counter #(
        .TOTAL  (V_TOTAL),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .W      (VW)
    ) uVert (
        .clk25175KHz (clk25175KHz),
        .reset       (reset),
        .advance     (hWrap),
        .count       (vcnt),
        .wrap        (),
        .active      (vActive),
        .syncC       (vSyncC)
    );

    always_comb begin
        visC       = hActive & vActive;
        x          = hcnt;
        y          = vcnt;
        pixelReq   = visC;
        lineStart  = (hcnt == '0) & ~reset;
        frameStart = (hcnt == '0) & (vcnt == '0) & ~reset;
    end

    // Blanking forces colour to zero so nothing the source drives off-screen reaches the DAC.
    always_ff @(posedge clk25175KHz) begin
        if (reset) begin
            redOut    <= '0;
            greenOut  <= '0;
            blueOut   <= '0;
            hSync     <= ~H_SYNC_POL;
            vSync     <= ~V_SYNC_POL;
            activeOut <= 1'b0;
        end else begin
            redOut    <= visC ? redIn   : '0;
            greenOut  <= visC ? greenIn : '0;
            blueOut   <= visC ? blueIn  : '0;
            hSync     <= hSyncC ? H_SYNC_POL : ~H_SYNC_POL;
            vSync     <= vSyncC ? V_SYNC_POL : ~V_SYNC_POL;
            activeOut <= visC;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line timing and mid-frame reset, and a tiny
// positive-polarity 4-bit instance for full-frame timing and colour gating.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-mode instance
    logic       rstA;
    logic       rA, gA, bA;
    logic [9:0] xA, yA;
    logic       prA, lsA, fsA, rOA, gOA, bOA, hSA, vSA, actA;

    vga_timing_gen dutA (
        .clk25175KHz (clk),
        .reset       (rstA),
        .redIn       (rA),
        .greenIn     (gA),
        .blueIn      (bA),
        .x           (xA),
        .y           (yA),
        .pixelReq    (prA),
        .lineStart   (lsA),
        .frameStart  (fsA),
        .redOut      (rOA),
        .greenOut    (gOA),
        .blueOut     (bOA),
        .hSync       (hSA),
        .vSync       (vSA),
        .activeOut   (actA)
    );

    // Small-mode instance: line 8 clocks, frame 6 lines
    logic       rstB;
    logic [3:0] rB, gB, bB;
    logic [2:0] xB, yB;
    logic       prB, lsB, fsB, hSB, vSB, actB;
    logic [3:0] rOB, gOB, bOB;

    assign rB = {xB[1:0], yB[1:0]};
    assign gB = 4'hA;
    assign bB = ~rB;

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b1), .COLOR_W (4)
    ) dutB (
        .clk25175KHz (clk),
        .reset       (rstB),
        .redIn       (rB),
        .greenIn     (gB),
        .blueIn      (bB),
        .x           (xB),
        .y           (yB),
        .pixelReq    (prB),
        .lineStart   (lsB),
        .frameStart  (fsB),
        .redOut      (rOB),
        .greenOut    (gOB),
        .blueOut     (bOB),
        .hSync       (hSB),
        .vSync       (vSB),
        .activeOut   (actB)
    );

    int total  = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int   errXY, errAct, errCol, errH, errV, errLs, errFs, errPr;
    int   hLow1, hLow2, firstLow, actCnt1, lsCnt, lsT0, lsT1;
    int   p, px, py, lowCnt;
    int   hHighB, vHighB, fsCntB, actCntB;
    logic vis, expH, expV, expFs;
    logic [3:0] expR, expG, expBl;
    logic [1:0] phLo, pvLo;

    initial begin
        rstA = 1'b1; rstB = 1'b1;
        rA = 1'b1; gA = 1'b1; bA = 1'b1;

        // Reset held for 5 clocks
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstA_hSync", hSA, 1);
            check("rstA_vSync", vSA, 1);
            check("rstA_colour", {rOA, gOA, bOA}, 0);
            check("rstA_active", actA, 0);
            check("rstA_frameStart", fsA, 0);
            check("rstA_lineStart", lsA, 0);
        end
        rstA = 1'b0;
        #1;
        check("postRstA_x", xA, 0);
        check("postRstA_y", yA, 0);
        check("postRstA_frameStart", fsA, 1);
        check("postRstA_lineStart", lsA, 1);
        check("postRstA_pixelReq", prA, 1);

        // Two full lines of the default mode
        errXY = 0; errAct = 0; errCol = 0; errH = 0; errV = 0; errLs = 0; errFs = 0; errPr = 0;
        hLow1 = 0; hLow2 = 0; firstLow = -1; actCnt1 = 0; lsCnt = 0; lsT0 = -1; lsT1 = -1;
        for (int k = 1; k <= 1600; k++) begin
            tick();
            if (xA !== 10'(k % 800) || yA !== 10'(k / 800)) errXY++;
            if (prA !== ((k % 800) < 640)) errPr++;
            p  = k - 1;
            px = p % 800;
            py = p / 800;
            vis  = (px < 640) && (py < 480);
            expH = !((px >= 656) && (px < 752));
            if (actA !== vis) errAct++;
            if (rOA !== vis || gOA !== vis || bOA !== vis) errCol++;
            if (hSA !== expH) errH++;
            if (vSA !== 1'b1) errV++;
            if (lsA !== ((k % 800) == 0)) errLs++;
            if (fsA !== 1'b0) errFs++;
            if (lsA) begin
                lsCnt++;
                if (lsT0 < 0) lsT0 = k; else lsT1 = k;
            end
            if (k <= 800) begin
                if (!hSA) begin
                    hLow1++;
                    if (firstLow < 0) firstLow = k;
                end
                if (actA) actCnt1++;
            end else if (!hSA) begin
                hLow2++;
            end
        end
        check("lineA_xy_track", errXY, 0);
        check("lineA_pixelReq", errPr, 0);
        check("lineA_active_track", errAct, 0);
        check("lineA_colour_gating", errCol, 0);
        check("lineA_hSync_track", errH, 0);
        check("lineA_vSync_idle", errV, 0);
        check("lineA_lineStart_track", errLs, 0);
        check("lineA_no_frameStart", errFs, 0);
        check("lineA_hLow_line1", hLow1, 96);
        check("lineA_hLow_line2", hLow2, 96);
        check("lineA_hLow_start", firstLow, 657);
        check("lineA_active_len", actCnt1, 640);
        check("lineA_lineStart_count", lsCnt, 2);
        check("lineA_lineStart_first", lsT0, 800);
        check("lineA_lineStart_period", lsT1 - lsT0, 800);

        // Mid-frame reset while hSync is asserted
        for (int k = 0; k < 700; k++) tick();
        check("midA_x", xA, 700);
        check("midA_y", yA, 2);
        check("midA_hSync_low", hSA, 0);
        rstA = 1'b1;
        tick();
        check("midRstA_x", xA, 0);
        check("midRstA_y", yA, 0);
        check("midRstA_hSync", hSA, 1);
        check("midRstA_vSync", vSA, 1);
        check("midRstA_active", actA, 0);
        check("midRstA_colour", {rOA, gOA, bOA}, 0);
        check("midRstA_lineStart_gated", lsA, 0);
        check("midRstA_frameStart_gated", fsA, 0);
        rstA = 1'b0;
        #1;
        check("midRelA_frameStart", fsA, 1);
        check("midRelA_x", xA, 0);
        check("midRelA_y", yA, 0);
        lowCnt = 0;
        for (int k = 1; k <= 656; k++) begin
            tick();
            if (!hSA) lowCnt++;
        end
        check("midRelA_no_partial_hSync", lowCnt, 0);
        tick();
        check("midRelA_hSync_first_low", hSA, 0);

        // Small mode: reset has been held since time zero
        check("rstB_hSync", hSB, 0);
        check("rstB_vSync", vSB, 0);
        check("rstB_active", actB, 0);
        check("rstB_colour", {rOB, gOB, bOB}, 0);
        check("rstB_frameStart", fsB, 0);
        check("rstB_lineStart", lsB, 0);
        rstB = 1'b0;
        #1;
        check("postRstB_frameStart", fsB, 1);
        check("postRstB_xy", {xB, yB}, 0);

        // Two full frames of the small mode
        errXY = 0; errAct = 0; errCol = 0; errH = 0; errV = 0; errFs = 0; errPr = 0;
        hHighB = 0; vHighB = 0; fsCntB = 0; actCntB = 0;
        for (int k = 1; k <= 96; k++) begin
            tick();
            if (xB !== 3'(k % 8) || yB !== 3'((k / 8) % 6)) errXY++;
            if (prB !== (((k % 8) < 4) && (((k / 8) % 6) < 3))) errPr++;
            p  = k - 1;
            px = p % 8;
            py = (p / 8) % 6;
            phLo  = px[1:0];
            pvLo  = py[1:0];
            vis   = (px < 4) && (py < 3);
            expH  = (px == 5) || (px == 6);
            expV  = (py == 4);
            expFs = ((k % 48) == 0);
            expR  = vis ? {phLo, pvLo} : 4'h0;
            expG  = vis ? 4'hA : 4'h0;
            expBl = vis ? ~{phLo, pvLo} : 4'h0;
            if (actB !== vis) errAct++;
            if (rOB !== expR || gOB !== expG || bOB !== expBl) errCol++;
            if (hSB !== expH) errH++;
            if (vSB !== expV) errV++;
            if (fsB !== expFs) errFs++;
            if (hSB) hHighB++;
            if (vSB) vHighB++;
            if (fsB) fsCntB++;
            if (actB) actCntB++;
            if (k == 47) begin
                check("wrapB_last_x", xB, 7);
                check("wrapB_last_y", yB, 5);
                check("wrapB_last_noFrameStart", fsB, 0);
            end
            if (k == 48) begin
                check("wrapB_x0", xB, 0);
                check("wrapB_y0", yB, 0);
                check("wrapB_frameStart", fsB, 1);
            end
        end
        check("frameB_xy_track", errXY, 0);
        check("frameB_pixelReq", errPr, 0);
        check("frameB_active_track", errAct, 0);
        check("frameB_colour_gating", errCol, 0);
        check("frameB_hSync_track", errH, 0);
        check("frameB_vSync_track", errV, 0);
        check("frameB_frameStart_track", errFs, 0);
        check("frameB_hHigh_count", hHighB, 24);
        check("frameB_vHigh_count", vHighB, 16);
        check("frameB_frameStart_count", fsCntB, 2);
        check("frameB_active_count", actCntB, 24);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
